// File: rtl/fft_apb_master.sv
// Command-to-APB bridge: one outstanding register access per command.
// Define FFT_APB_MASTER_TIMEOUT_EN to abort stalled ACCESS phases.
module fft_apb_master #(
  parameter int APB_ADDR_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_write_i,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [31:0]               cmd_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [31:0]               rsp_rdata_o,
  output logic                      rsp_error_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [31:0]               pwdata_o,
  input  logic [31:0]               prdata_i,
  input  logic                      pready_i
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]                state_q;
  logic                      rst_q;
  logic                      pwrite_q;
  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic [31:0]               pwdata_q;
  logic [31:0]               rdata_q;
  logic                      timeout;

  // Hold off acceptance for one cycle after reset releases
  assign cmd_ready_o = (state_q == S_IDLE) && !rst_q;
  assign psel_o      = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign penable_o   = (state_q == S_ACCESS);
  assign rsp_valid_o = (state_q == S_RESP);
  assign pwrite_o    = pwrite_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;
  assign rsp_rdata_o = rdata_q;

`ifdef FFT_APB_MASTER_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       err_q;

  assign timeout = (state_q == S_ACCESS) && !pready_i &&
                   (cnt_q == 8'(TIMEOUT_CYCLES - 1));
  assign rsp_error_o = err_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (state_q == S_SETUP) begin
      cnt_q <= '0;
    end else if (state_q == S_ACCESS) begin
      if (pready_i) begin
        err_q <= 1'b0;
      end else if (timeout) begin
        err_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end
`else
  assign timeout     = 1'b0;
  assign rsp_error_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      rst_q    <= 1'b1;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rdata_q  <= '0;
    end else begin
      rst_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            pwrite_q <= cmd_write_i;
            paddr_q  <= cmd_addr_i;
            pwdata_q <= cmd_wdata_i;
            state_q  <= S_SETUP;
          end
        end
        S_SETUP: state_q <= S_ACCESS;
        S_ACCESS: begin
          if (pready_i) begin
            rdata_q <= pwrite_q ? 32'd0 : prdata_i;
            state_q <= S_RESP;
          end else if (timeout) begin
            rdata_q <= 32'd0;
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_apb_master.sv
// Self-checking bench for fft_apb_master: directed and random APB accesses.
module tb_fft_apb_master;

  localparam int AW = 16;
  localparam int TO = 4;
`ifdef FFT_APB_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic          cmd_write_i = 1'b0;
  logic [AW-1:0] cmd_addr_i = '0;
  logic [31:0]   cmd_wdata_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [31:0]   rsp_rdata_o;
  logic          rsp_error_o;
  logic          psel_o;
  logic          penable_o;
  logic          pwrite_o;
  logic [AW-1:0] paddr_o;
  logic [31:0]   pwdata_o;
  logic [31:0]   prdata_i = '0;
  logic          pready_i = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fft_apb_master #(
    .APB_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i),
    .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_error_o(rsp_error_o),
    .psel_o(psel_o),
    .penable_o(penable_o),
    .pwrite_o(pwrite_o),
    .paddr_o(paddr_o),
    .pwdata_o(pwdata_o),
    .prdata_i(prdata_i),
    .pready_i(pready_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge idle.
  task automatic txn(input bit wr, input logic [AW-1:0] addr,
                     input logic [31:0] wd, input int wt,
                     input logic [31:0] rd, input int hold);
    bit          exp_err;
    int          n_acc;
    logic [31:0] exp_rd;
    exp_err = TO_EN && (wt >= TO);
    n_acc   = exp_err ? TO : wt + 1;
    exp_rd  = (exp_err || wr) ? 32'd0 : rd;

    chk("idle_ready", {31'd0, cmd_ready_o}, 32'd1);
    cmd_valid_i = 1'b1;
    cmd_write_i = wr;
    cmd_addr_i  = addr;
    cmd_wdata_i = wd;

    @(negedge clk);
    cmd_valid_i = 1'($urandom);
    cmd_write_i = ~wr;
    cmd_addr_i  = AW'($urandom);
    cmd_wdata_i = $urandom;
    pready_i    = 1'b1;
    prdata_i    = $urandom;
    chk("setup_psel", {31'd0, psel_o}, 32'd1);
    chk("setup_pen", {31'd0, penable_o}, 32'd0);
    chk("setup_addr", 32'(paddr_o), 32'(addr));
    chk("setup_pwrite", {31'd0, pwrite_o}, {31'd0, wr});
    chk("setup_wdata", pwdata_o, wd);
    chk("setup_ready", {31'd0, cmd_ready_o}, 32'd0);

    for (int k = 0; k < n_acc; k++) begin
      @(negedge clk);
      chk("acc_psel", {31'd0, psel_o}, 32'd1);
      chk("acc_pen", {31'd0, penable_o}, 32'd1);
      chk("acc_addr", 32'(paddr_o), 32'(addr));
      chk("acc_wdata", pwdata_o, wd);
      chk("acc_rspv", {31'd0, rsp_valid_o}, 32'd0);
      pready_i = (k == wt);
      prdata_i = (k == wt) ? rd : $urandom;
    end

    @(negedge clk);
    pready_i    = 1'($urandom);
    prdata_i    = $urandom;
    rsp_ready_i = 1'b0;
    cmd_valid_i = 1'b1;
    chk("resp_valid", {31'd0, rsp_valid_o}, 32'd1);
    chk("resp_rdata", rsp_rdata_o, exp_rd);
    chk("resp_err", {31'd0, rsp_error_o}, {31'd0, exp_err});
    chk("resp_psel", {31'd0, psel_o}, 32'd0);
    chk("resp_pen", {31'd0, penable_o}, 32'd0);
    chk("resp_ready", {31'd0, cmd_ready_o}, 32'd0);

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      pready_i = 1'($urandom);
      prdata_i = $urandom;
      chk("hold_valid", {31'd0, rsp_valid_o}, 32'd1);
      chk("hold_rdata", rsp_rdata_o, exp_rd);
      chk("hold_err", {31'd0, rsp_error_o}, {31'd0, exp_err});
      chk("hold_cready", {31'd0, cmd_ready_o}, 32'd0);
      chk("hold_psel", {31'd0, psel_o}, 32'd0);
    end
    rsp_ready_i = 1'b1;

    @(negedge clk);
    cmd_valid_i = 1'b0;
    rsp_ready_i = 1'b0;
    pready_i    = 1'b0;
    chk("back_rspv", {31'd0, rsp_valid_o}, 32'd0);
    chk("back_psel", {31'd0, psel_o}, 32'd0);
    chk("back_addr", 32'(paddr_o), 32'(addr));
    chk("back_pwrite", {31'd0, pwrite_o}, {31'd0, wr});
    chk("back_cready", {31'd0, cmd_ready_o}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_cready", {31'd0, cmd_ready_o}, 32'd0);
    chk("rst_psel", {31'd0, psel_o}, 32'd0);
    chk("rst_pen", {31'd0, penable_o}, 32'd0);
    chk("rst_addr", 32'(paddr_o), 32'd0);
    chk("rst_wdata", pwdata_o, 32'd0);
    chk("rst_pwrite", {31'd0, pwrite_o}, 32'd0);
    chk("rst_rspv", {31'd0, rsp_valid_o}, 32'd0);
    chk("rst_rdata", rsp_rdata_o, 32'd0);
    chk("rst_err", {31'd0, rsp_error_o}, 32'd0);
    reset_i = 1'b0;
    @(negedge clk);

    txn(1'b1, 16'h000C, 32'h0000_0400, 0, 32'hDEAD_BEEF, 0);
    txn(1'b0, 16'h0004, 32'h1111_2222, 2, 32'h00A5_0003, 1);
    txn(1'b0, 16'h0008, 32'h0, 0, 32'h1234_5678, 5);
    txn(1'b0, 16'h0010, 32'h0, 20, 32'hCAFE_F00D, 0);
    txn(1'b1, 16'hFFFC, 32'hFFFF_FFFF, 3, 32'h5555_AAAA, 2);

    for (int i = 0; i < 20; i++) begin
      txn(1'($urandom), AW'($urandom), $urandom,
          int'($urandom_range(0, 6)), $urandom,
          int'($urandom_range(0, 5)));
    end

    // Reset during ACCESS of a write to address 0
    chk("r2_ready", {31'd0, cmd_ready_o}, 32'd1);
    cmd_valid_i = 1'b1;
    cmd_write_i = 1'b1;
    cmd_addr_i  = 16'h0000;
    cmd_wdata_i = 32'hA5A5_5A5A;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    pready_i    = 1'b0;
    @(negedge clk);
    chk("r2_acc_pen", {31'd0, penable_o}, 32'd1);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    chk("r2_psel", {31'd0, psel_o}, 32'd0);
    chk("r2_pen", {31'd0, penable_o}, 32'd0);
    chk("r2_rspv", {31'd0, rsp_valid_o}, 32'd0);
    chk("r2_cready0", {31'd0, cmd_ready_o}, 32'd0);
    chk("r2_wdata", pwdata_o, 32'd0);
    @(negedge clk);
    chk("r2_cready1", {31'd0, cmd_ready_o}, 32'd1);
    chk("r2_rspv1", {31'd0, rsp_valid_o}, 32'd0);

    txn(1'b0, 16'h0020, 32'h0, 1, 32'h0BAD_C0DE, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
